// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - round-robin arbiter sharing one D-cache port among load/store requesters
//
// Purpose: grants the single D-cache port to one of NUM_REQ requesters at a
// time. The grant is held until the cache answers with mem_resp_i. The response
// pulse is routed back to the owner only.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   req_read_i/req_write_i    per-requester read / write request (both set = write)
//   req_addr_i/req_wdata_i    per-requester address and lane-shifted store data
//   req_byte_en_i             per-requester byte enables
//   req_resp_o                one-hot response pulse to the current owner
//   req_rdata_o               cache read data broadcast to every requester
//   mem_*_o                   request side of the shared D-cache port
//   mem_resp_i/mem_data_i     cache response and read data
//   grant_o                   one-hot owner (combinational in IDLE, registered in BUSY)

module dcache_port_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_read_i,
   input  logic [NUM_REQ-1:0]       req_write_i,
   input  logic [NUM_REQ-1:0][31:0] req_addr_i,
   input  logic [NUM_REQ-1:0][31:0] req_wdata_i,
   input  logic [NUM_REQ-1:0][3:0]  req_byte_en_i,
   output logic [NUM_REQ-1:0]       req_resp_o,
   output logic [31:0]              req_rdata_o,
   output logic                     mem_read_o,
   output logic                     mem_write_o,
   output logic [31:0]              mem_addr_o,
   output logic [31:0]              mem_data_o,
   output logic [3:0]               mem_byte_en_o,
   input  logic                     mem_resp_i,
   input  logic [31:0]              mem_data_i,
   output logic [NUM_REQ-1:0]       grant_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     gnt_q, gnt_d;
   logic [1:0]           op_q, op_d;        // {write, read}
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           ben_q, ben_d;

   logic [NUM_REQ-1:0]   req_any;
   logic                 win_vld;
   logic [IDX_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]   win_oh;
   logic [NUM_REQ-1:0]   gnt_oh;
   logic                 win_rd;
   logic                 win_wr;
   logic [31:0]          win_addr;
   logic [31:0]          win_wdata;
   logic [3:0]           win_ben;

   assign req_any     = req_read_i | req_write_i;
   assign req_rdata_o = mem_data_i;

   // Round-robin pick: first requester at or above rr_ptr_q, otherwise the
   // first one from index 0. Together the two passes form the wrap-around search.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_vld && req_any[i] && (IDX_W'(i) >= rr_ptr_q)) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_vld && req_any[i]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      win_oh = '0;
      gnt_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_oh[i] = win_vld && (win_idx == IDX_W'(i));
         gnt_oh[i] = (gnt_q == IDX_W'(i));
      end
   end

   // Winner's fields. A simultaneous read+write is treated as a write only.
   always_comb begin
      win_rd    = 1'b0;
      win_wr    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      win_ben   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) begin
            win_wr    = req_write_i[i];
            win_rd    = req_read_i[i] & ~req_write_i[i];
            win_addr  = req_addr_i[i];
            win_wdata = req_wdata_i[i];
            win_ben   = req_byte_en_i[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ben_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ben_q    <= ben_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      gnt_d         = gnt_q;
      op_d          = op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      ben_d         = ben_q;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      mem_byte_en_o = '0;
      req_resp_o    = '0;
      grant_o       = '0;

      case (state_q)
         ST_IDLE: begin
            // mem_resp_i is deliberately ignored here, so a response to a
            // transaction aborted by reset cannot reach any requester.
            if (win_vld) begin
               mem_read_o    = win_rd;
               mem_write_o   = win_wr;
               mem_addr_o    = win_addr;
               mem_data_o    = win_wdata;
               mem_byte_en_o = win_ben;
               grant_o       = win_oh;
               gnt_d         = win_idx;
               op_d          = {win_wr, win_rd};
               addr_d        = win_addr;
               wdata_d       = win_wdata;
               ben_d         = win_ben;
               state_d       = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Requester inputs are not looked at while the transaction is open.
            mem_write_o   = op_q[1];
            mem_read_o    = op_q[0];
            mem_addr_o    = addr_q;
            mem_data_o    = wdata_q;
            mem_byte_en_o = ben_q;
            grant_o       = gnt_oh;
            if (mem_resp_i) begin
               req_resp_o = gnt_oh;
               rr_ptr_d   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
               state_d    = ST_IDLE;
            end
         end
      endcase

      // The IDLE path is combinational from the requesters, so it has to be
      // forced quiet while reset is held.
      if (!rst) begin
         mem_read_o    = 1'b0;
         mem_write_o   = 1'b0;
         mem_addr_o    = '0;
         mem_data_o    = '0;
         mem_byte_en_o = '0;
         req_resp_o    = '0;
         grant_o       = '0;
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - self-checking bench for dcache_port_arbiter (NUM_REQ 2 and 3)

module tb_dcache_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [2:0]       rd, wr;
   logic [2:0][31:0] addr, wdata;
   logic [2:0][3:0]  ben;
   logic             mem_resp;
   logic [31:0]      mem_rdata;

   logic [1:0]  a_resp, a_grant;
   logic [31:0] a_rdata, a_maddr, a_mdata;
   logic        a_mrd, a_mwr;
   logic [3:0]  a_mben;

   logic [2:0]  b_resp, b_grant;
   logic [31:0] b_rdata, b_maddr, b_mdata;
   logic        b_mrd, b_mwr;
   logic [3:0]  b_mben;

   dcache_port_arbiter #(.NUM_REQ(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_read_i(rd[1:0]), .req_write_i(wr[1:0]),
      .req_addr_i(addr[1:0]), .req_wdata_i(wdata[1:0]), .req_byte_en_i(ben[1:0]),
      .req_resp_o(a_resp), .req_rdata_o(a_rdata),
      .mem_read_o(a_mrd), .mem_write_o(a_mwr), .mem_addr_o(a_maddr),
      .mem_data_o(a_mdata), .mem_byte_en_o(a_mben),
      .mem_resp_i(mem_resp), .mem_data_i(mem_rdata), .grant_o(a_grant)
   );

   dcache_port_arbiter #(.NUM_REQ(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_read_i(rd), .req_write_i(wr),
      .req_addr_i(addr), .req_wdata_i(wdata), .req_byte_en_i(ben),
      .req_resp_o(b_resp), .req_rdata_o(b_rdata),
      .mem_read_o(b_mrd), .mem_write_o(b_mwr), .mem_addr_o(b_maddr),
      .mem_data_o(b_mdata), .mem_byte_en_o(b_mben),
      .mem_resp_i(mem_resp), .mem_data_i(mem_rdata), .grant_o(b_grant)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level reference: one open transaction per DUT plus a pointer.
   bit          m_busy [2] = '{0, 0};
   int          m_owner[2] = '{0, 0};
   int          m_rr   [2] = '{0, 0};
   bit          m_wr   [2];
   bit          m_rd   [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_data [2];
   logic [3:0]  m_ben  [2];

   logic [2:0]  last_grant[2];
   logic [2:0]  last_resp [2];
   logic        last_mrd  [2];
   logic        last_mwr  [2];
   logic [31:0] last_maddr[2];
   logic [31:0] last_mdata[2];
   logic [3:0]  last_mben [2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      rd = '0; wr = '0; addr = '0; wdata = '0; ben = '0;
      mem_resp = 1'b0; mem_rdata = '0;
   endtask

   // Samples both DUTs at the falling edge, compares with the model and
   // advances the model by one cycle; returns just after the next rising edge.
   task automatic step();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         int          n;
         int          w;
         string       p;
         logic [2:0]  g_grant, g_resp, e_grant, e_resp;
         logic        g_rd, g_wr, e_rd, e_wr;
         logic [31:0] g_addr, g_data, g_rdata, e_addr, e_data;
         logic [3:0]  g_ben, e_ben;
         n = (d == 0) ? 2 : 3;
         p = (d == 0) ? "A" : "B";
         if (d == 0) begin
            g_grant = {1'b0, a_grant}; g_resp = {1'b0, a_resp}; g_rd = a_mrd; g_wr = a_mwr;
            g_addr = a_maddr; g_data = a_mdata; g_ben = a_mben; g_rdata = a_rdata;
         end else begin
            g_grant = b_grant; g_resp = b_resp; g_rd = b_mrd; g_wr = b_mwr;
            g_addr = b_maddr; g_data = b_mdata; g_ben = b_mben; g_rdata = b_rdata;
         end
         e_grant = '0; e_resp = '0; e_rd = 1'b0; e_wr = 1'b0;
         e_addr = '0; e_data = '0; e_ben = '0;
         if (!rst) begin
            m_busy[d] = 0; m_rr[d] = 0; m_owner[d] = 0;
         end else if (m_busy[d]) begin
            e_grant = 3'(1 << m_owner[d]);
            e_rd = m_rd[d]; e_wr = m_wr[d];
            e_addr = m_addr[d]; e_data = m_data[d]; e_ben = m_ben[d];
            if (mem_resp) begin
               e_resp = 3'(1 << m_owner[d]);
               m_busy[d] = 0;
               m_rr[d] = (m_owner[d] + 1) % n;
            end
         end else begin
            w = -1;
            for (int k = 0; k < n; k++) begin
               int idx;
               idx = (m_rr[d] + k) % n;
               if (w < 0 && (rd[idx] || wr[idx])) w = idx;
            end
            if (w >= 0) begin
               e_grant = 3'(1 << w);
               e_wr = wr[w];
               e_rd = rd[w] && !wr[w];
               e_addr = addr[w]; e_data = wdata[w]; e_ben = ben[w];
               m_busy[d] = 1; m_owner[d] = w;
               m_wr[d] = e_wr; m_rd[d] = e_rd;
               m_addr[d] = e_addr; m_data[d] = e_data; m_ben[d] = e_ben;
            end
         end
         chk({p, " grant"},    g_grant, e_grant);
         chk({p, " resp"},     g_resp,  e_resp);
         chk({p, " mem_read"}, g_rd,    e_rd);
         chk({p, " mem_write"},g_wr,    e_wr);
         chk({p, " mem_addr"}, g_addr,  e_addr);
         chk({p, " mem_data"}, g_data,  e_data);
         chk({p, " mem_ben"},  g_ben,   e_ben);
         chk({p, " rdata"},    g_rdata, mem_rdata);
         last_grant[d] = g_grant; last_resp[d] = g_resp;
         last_mrd[d] = g_rd; last_mwr[d] = g_wr;
         last_maddr[d] = g_addr; last_mdata[d] = g_data; last_mben[d] = g_ben;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      int  resp_cnt;
      bit  r0_seen;
      bit  tbl5[5];
      bit  tbl4[4];

      rst = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      do_reset();

      // Lone read from requester 1, cache answers three cycles later.
      tbl5 = '{0, 0, 0, 1, 0};
      rd[1] = 1'b1; addr[1] = 32'h0000_1000; ben[1] = 4'hF;
      resp_cnt = 0; r0_seen = 0;
      for (int t = 0; t < 5; t++) begin
         mem_resp = tbl5[t];
         mem_rdata = tbl5[t] ? 32'hDEAD_BEEF : 32'h0;
         if (t == 4) rd[1] = 1'b0;
         step();
         r0_seen |= last_resp[0][0];
         resp_cnt += int'(last_resp[0][1]);
         if (t == 0) begin
            chk("t1 zero-latency read", last_mrd[0], 1'b1);
            chk("t1 addr", last_maddr[0], 32'h0000_1000);
            chk("t1 grant", last_grant[0], 3'b010);
         end
         if (t == 3) chk("t1 resp pulse", last_resp[0], 3'b010);
      end
      chk("t1 resp count", resp_cnt, 1);
      chk("t1 resp0 never", r0_seen, 1'b0);

      // Two continuous requesters from reset with 1-cycle cache latency.
      do_reset();
      rd[0] = 1'b1; rd[1] = 1'b1;
      addr[0] = 32'h0000_0100; addr[1] = 32'h0000_0200;
      for (int t = 0; t < 12; t++) begin
         mem_resp = t[0];
         step();
         if (t % 2 == 0) begin
            chk("t2 grant seq", last_grant[0], ((t / 2) % 2 == 0) ? 3'b001 : 3'b010);
            chk("t2 back-to-back", last_mrd[0], 1'b1);
         end
      end
      clear_inputs();

      // Write held stable although requester 0 withdraws after the grant.
      tbl5 = '{0, 0, 0, 1, 0};
      wr[0] = 1'b1; addr[0] = 32'h0000_2004; wdata[0] = 32'h00AB_0000; ben[0] = 4'b0100;
      resp_cnt = 0;
      for (int t = 0; t < 5; t++) begin
         mem_resp = tbl5[t];
         if (t == 1) begin
            wr[0] = 1'b0; addr[0] = 32'hFFFF_FFFC; wdata[0] = $urandom; ben[0] = 4'b1011;
         end
         step();
         resp_cnt += int'(last_resp[0][0]);
         if (t < 4) begin
            chk("t3 mem_write", last_mwr[0], 1'b1);
            chk("t3 addr", last_maddr[0], 32'h0000_2004);
            chk("t3 data", last_mdata[0], 32'h00AB_0000);
            chk("t3 ben", last_mben[0], 4'b0100);
         end
      end
      chk("t3 resp count", resp_cnt, 1);

      // Read and write together: only a write reaches the cache.
      tbl4 = '{0, 0, 1, 0};
      rd[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h0000_3000; ben[1] = 4'hF;
      for (int t = 0; t < 4; t++) begin
         mem_resp = tbl4[t];
         if (t == 3) begin rd[1] = 1'b0; wr[1] = 1'b0; end
         step();
         if (t < 3) begin
            chk("t4 write wins", last_mwr[0], 1'b1);
            chk("t4 no read", last_mrd[0], 1'b0);
         end
      end

      // Asynchronous reset between edges while a transaction is open.
      rd[1] = 1'b1; addr[1] = 32'h0000_4000; ben[1] = 4'h3;
      step();
      rd[0] = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("t5 A outputs in reset", {a_mrd, a_mwr, a_maddr, a_mdata, a_mben, a_resp, a_grant}, '0);
      chk("t5 B outputs in reset", {b_mrd, b_mwr, b_maddr, b_mdata, b_mben, b_resp, b_grant}, '0);
      step();
      rst = 1'b1;
      clear_inputs();
      mem_resp = 1'b1;
      step();
      chk("t5 stale resp ignored", last_resp[0], 3'b000);
      mem_resp = 1'b0;
      rd[0] = 1'b1; rd[1] = 1'b1;
      step();
      chk("t5 grant after reset", last_grant[0], 3'b001);
      mem_resp = 1'b1;
      step();
      clear_inputs();

      // Three requesters: rotation wraps 0,1,2,0.
      do_reset();
      rd = 3'b111;
      for (int t = 0; t < 8; t++) begin
         mem_resp = t[0];
         step();
         if (t % 2 == 0) begin
            case (t / 2)
               0: chk("t6 grant 0", last_grant[1], 3'b001);
               1: chk("t6 grant 1", last_grant[1], 3'b010);
               2: chk("t6 grant 2", last_grant[1], 3'b100);
               default: chk("t6 grant wrap", last_grant[1], 3'b001);
            endcase
         end
      end
      clear_inputs();

      // Randomised traffic, checked cycle by cycle against the model.
      for (int t = 0; t < 800; t++) begin
         for (int i = 0; i < 3; i++) begin
            rd[i] = ($urandom_range(0, 2) == 0);
            wr[i] = ($urandom_range(0, 3) == 0);
            addr[i] = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            wdata[i] = $urandom;
            ben[i] = 4'($urandom);
         end
         mem_resp = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         rst = ($urandom_range(0, 99) != 0);
         step();
      end
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
